// File: rtl/membus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : membus_arbiter
// Description : Arbitrates N master request ports onto a single slave memory
//               port. The grant is combinational among the requesting masters.
//               A grant that is stalled by the slave stays locked on the same
//               master. Accepted requests push the granted master index into
//               a response-tag FIFO. Slave responses, which come back in
//               order, pop that FIFO and go to the owning master in the
//               same cycle. A response with nothing in flight sets a sticky
//               orphan error flag.
//
//               Build option MEMBUS_ARB_FIXED_PRIO_EN:
//                 defined   -> fixed priority, lowest master index wins;
//                              there is no round-robin pointer.
//                 undefined -> round-robin grant starting at the master
//                              after the last one accepted.
//
// Ports       : clk, rst            clock, synchronous active-high reset
//               m_valid/m_ready     per-master request handshake
//               m_addr              per-master byte address
//               m_wen/m_wdata/m_wmask  per-master write controls
//               m_rvalid            per-master response strobe
//               m_rdata             shared response data
//               s_valid/s_ready     slave request handshake
//               s_addr              slave word address
//               s_wen/s_wdata/s_wmask  forwarded write controls
//               s_rvalid/s_rdata    slave response
//               outstanding         number of requests in flight
//               err_orphan          sticky flag for a response with nothing in flight
//
// Revision    : 1.0 - initial release
// ============================================================================
module membus_arbiter #(
    parameter int NUM_MASTERS     = 2,
    parameter int DATA_WIDTH      = 64,
    parameter int IN_ADDR_WIDTH   = 32,
    parameter int ADDR_WIDTH      = 10,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_MASTERS-1:0]               m_valid,
    output logic [NUM_MASTERS-1:0]               m_ready,
    input  logic [NUM_MASTERS*IN_ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS-1:0]               m_wen,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_wdata,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]  m_wmask,
    output logic [NUM_MASTERS-1:0]               m_rvalid,
    output logic [DATA_WIDTH-1:0]                m_rdata,
    output logic                                 s_valid,
    input  logic                                 s_ready,
    output logic [ADDR_WIDTH-1:0]                s_addr,
    output logic                                 s_wen,
    output logic [DATA_WIDTH-1:0]                s_wdata,
    output logic [DATA_WIDTH/8-1:0]              s_wmask,
    input  logic                                 s_rvalid,
    input  logic [DATA_WIDTH-1:0]                s_rdata,
    output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
    output logic                                 err_orphan
);

    localparam int c_IDX_W    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int c_PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int c_CNT_W    = $clog2(MAX_OUTSTANDING) + 1;
    localparam int c_STRB_W   = DATA_WIDTH / 8;
    localparam int c_BYTE_LSB = $clog2(c_STRB_W);

    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_MASTERS - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT  = c_CNT_W'(MAX_OUTSTANDING);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                 r_lock_q;
    logic                 w_lock_d;
    logic [c_IDX_W-1:0]   r_lock_idx_q;
    logic [c_IDX_W-1:0]   w_lock_idx_d;
    logic [c_PTR_W-1:0]   r_wr_ptr_q;
    logic [c_PTR_W-1:0]   w_wr_ptr_d;
    logic [c_PTR_W-1:0]   r_rd_ptr_q;
    logic [c_PTR_W-1:0]   w_rd_ptr_d;
    logic [c_CNT_W-1:0]   r_count_q;
    logic [c_CNT_W-1:0]   w_count_d;
    logic                 r_err_orphan_q;
    logic                 w_err_orphan_d;
    logic [c_IDX_W-1:0]   r_tag_mem [MAX_OUTSTANDING];

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic                 w_any_valid;
    logic                 w_fifo_empty;
    logic                 w_can_accept;
    logic                 w_accept;
    logic                 w_pop;
    logic                 w_lock_hit;
    logic [c_IDX_W-1:0]   w_scan_base;
    logic [c_IDX_W-1:0]   w_arb_idx;
    logic                 w_arb_found;
    logic [c_IDX_W-1:0]   w_gnt_idx;
    logic [c_IDX_W-1:0]   w_head_tag;
    int                   w_cand;
    logic                 w_unused_addr_bits;

    // Only the word-address slice of each master address reaches the slave.
    assign w_unused_addr_bits = ^m_addr;

    assign w_any_valid  = |m_valid;
    assign w_fifo_empty = (r_count_q == '0);
    // A response in the same cycle frees a slot, so a full FIFO may still
    // take a new request.
    assign w_can_accept = (r_count_q < c_MAX_CNT) || s_rvalid;

    // ------------------------------------------------------------------
    // Scan start point: fixed at 0, or the round-robin pointer
    // ------------------------------------------------------------------
`ifdef MEMBUS_ARB_FIXED_PRIO_EN
    assign w_scan_base = '0;
`else
    logic [c_IDX_W-1:0] r_rr_ptr_q;
    logic [c_IDX_W-1:0] w_rr_ptr_d;

    always_comb begin
        w_rr_ptr_d = r_rr_ptr_q;
        if (w_accept) begin
            w_rr_ptr_d = (w_gnt_idx == c_IDX_LAST) ? '0 : w_gnt_idx + c_IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr_q <= '0;
        end else begin
            r_rr_ptr_q <= w_rr_ptr_d;
        end
    end

    assign w_scan_base = r_rr_ptr_q;
`endif

    // First requesting master found when walking upward (with wrap)
    // from the scan base.
    always_comb begin
        w_arb_idx   = '0;
        w_arb_found = 1'b0;
        w_cand      = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            w_cand = int'(w_scan_base) + k;
            if (w_cand >= NUM_MASTERS) begin
                w_cand = w_cand - NUM_MASTERS;
            end
            if (!w_arb_found && m_valid[w_cand]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = c_IDX_W'(w_cand);
            end
        end
    end

    // A stalled grant stays with its master while that master keeps
    // requesting. If the master withdraws, arbitration restarts normally.
    assign w_lock_hit = r_lock_q && m_valid[r_lock_idx_q];
    assign w_gnt_idx  = w_lock_hit ? r_lock_idx_q : w_arb_idx;

    // ------------------------------------------------------------------
    // Request path
    // ------------------------------------------------------------------
    assign s_valid  = w_any_valid && w_can_accept && !rst;
    assign w_accept = s_valid && s_ready;
    assign m_ready  = (w_any_valid && s_ready && w_can_accept && !rst)
                      ? (NUM_MASTERS'(1) << w_gnt_idx) : '0;

    always_comb begin
        s_addr  = '0;
        s_wen   = 1'b0;
        s_wdata = '0;
        s_wmask = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (w_gnt_idx == c_IDX_W'(k)) begin
                s_addr  = m_addr[k*IN_ADDR_WIDTH + c_BYTE_LSB +: ADDR_WIDTH];
                s_wen   = m_wen[k];
                s_wdata = m_wdata[k*DATA_WIDTH +: DATA_WIDTH];
                s_wmask = m_wmask[k*c_STRB_W +: c_STRB_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response path
    // ------------------------------------------------------------------
    assign w_head_tag = r_tag_mem[r_rd_ptr_q];
    assign w_pop      = s_rvalid && !w_fifo_empty && !rst;
    assign m_rvalid   = w_pop ? (NUM_MASTERS'(1) << w_head_tag) : '0;
    assign m_rdata    = s_rdata;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_lock_d     = s_valid && !s_ready;
        w_lock_idx_d = w_gnt_idx;

        w_wr_ptr_d = r_wr_ptr_q;
        if (w_accept) begin
            w_wr_ptr_d = (r_wr_ptr_q == c_PTR_LAST) ? '0 : r_wr_ptr_q + c_PTR_W'(1);
        end

        w_rd_ptr_d = r_rd_ptr_q;
        if (w_pop) begin
            w_rd_ptr_d = (r_rd_ptr_q == c_PTR_LAST) ? '0 : r_rd_ptr_q + c_PTR_W'(1);
        end

        w_count_d = r_count_q;
        case ({w_accept, w_pop})
            2'b10:   w_count_d = r_count_q + c_CNT_W'(1);
            2'b01:   w_count_d = r_count_q - c_CNT_W'(1);
            default: w_count_d = r_count_q;
        endcase

        w_err_orphan_d = r_err_orphan_q || (s_rvalid && w_fifo_empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_q       <= 1'b0;
            r_lock_idx_q   <= '0;
            r_wr_ptr_q     <= '0;
            r_rd_ptr_q     <= '0;
            r_count_q      <= '0;
            r_err_orphan_q <= 1'b0;
        end else begin
            r_lock_q       <= w_lock_d;
            r_lock_idx_q   <= w_lock_idx_d;
            r_wr_ptr_q     <= w_wr_ptr_d;
            r_rd_ptr_q     <= w_rd_ptr_d;
            r_count_q      <= w_count_d;
            r_err_orphan_q <= w_err_orphan_d;
        end
    end

    // Tag storage is qualified by the count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_tag_mem[r_wr_ptr_q] <= w_gnt_idx;
        end
    end

    assign outstanding = r_count_q;
    assign err_orphan  = r_err_orphan_q;

endmodule
`default_nettype wire

// File: tb/tb_membus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_membus_arbiter
// Description : Self-checking bench for membus_arbiter with three masters and
//               four outstanding tags. Directed scenarios cover the handshake
//               rules. A randomized run is compared cycle by cycle against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_membus_arbiter;

    localparam int N   = 3;
    localparam int DW  = 64;
    localparam int IAW = 32;
    localparam int AW  = 10;
    localparam int MO  = 4;
    localparam int SW  = DW / 8;
    localparam int BL  = 3;      // byte offset bits of a 64-bit word

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    m_valid, m_ready, m_wen, m_rvalid;
    logic [N*IAW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [N*SW-1:0] m_wmask;
    logic [DW-1:0]   m_rdata;
    logic            s_valid, s_ready, s_wen, s_rvalid;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata, s_rdata;
    logic [SW-1:0]   s_wmask;
    logic [2:0]      outstanding;
    logic            err_orphan;

    always #5 clk = ~clk;

    membus_arbiter #(
        .NUM_MASTERS(N), .DATA_WIDTH(DW), .IN_ADDR_WIDTH(IAW),
        .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst(rst),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wen(m_wen),
        .m_wdata(m_wdata), .m_wmask(m_wmask), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wen(s_wen),
        .s_wdata(s_wdata), .s_wmask(s_wmask), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
        .outstanding(outstanding), .err_orphan(err_orphan)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    int md_rr;          // next master to favour
    int md_lock;        // master holding a stalled grant, -1 if none
    int md_q[$];        // owners of in-flight requests, oldest first
    bit md_orphan;

    int           e_g;
    bit           e_any, e_sval, e_acc, e_pop;
    logic [N-1:0] e_mready, e_mrvalid;
    logic [AW-1:0] e_addr;
    logic [2:0]   e_out;

    task automatic model_eval();
        int c;
        bit can;
        e_any = (m_valid != '0);
        can   = (md_q.size() < MO) || s_rvalid;
        e_g   = 0;
        if (md_lock >= 0 && m_valid[md_lock]) begin
            e_g = md_lock;
        end else begin
            // walk the order backwards so the earliest candidate is kept last
            for (int k = N - 1; k >= 0; k--) begin
                c = (md_rr + k) % N;
                if (m_valid[c]) e_g = c;
            end
        end
        e_sval    = e_any && can && !rst;
        e_acc     = e_sval && s_ready;
        e_mready  = e_acc ? (N'(1) << e_g) : '0;
        e_pop     = s_rvalid && (md_q.size() != 0) && !rst;
        e_mrvalid = e_pop ? (N'(1) << md_q[0]) : '0;
        e_addr    = AW'(m_addr[e_g*IAW +: IAW] >> BL);
        e_out     = 3'(md_q.size());
    endtask

    task automatic model_advance();
        if (rst) begin
            md_rr = 0; md_lock = -1; md_q.delete(); md_orphan = 1'b0;
        end else begin
            if (e_pop) void'(md_q.pop_front());
            else if (s_rvalid) md_orphan = 1'b1;
            if (e_acc) begin
                md_q.push_back(e_g);
`ifndef MEMBUS_ARB_FIXED_PRIO_EN
                md_rr = (e_g + 1) % N;
`endif
            end
            md_lock = (e_sval && !s_ready) ? e_g : -1;
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 ns later.
    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic next_cycle();
        model_advance();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m_valid = '0; m_wen = '0; s_ready = 1'b0; s_rvalid = 1'b0;
        m_addr = '0; m_wdata = '0; m_wmask = '0; s_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; idle_inputs();
        settle(); next_cycle();
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; m_valid = '1; s_ready = 1'b1; s_rvalid = 1'b1;
        m_addr = {$urandom, $urandom, $urandom};
        for (int i = 0; i < 2; i++) begin
            settle();
            n_vec++;
            if ({s_valid, m_ready, m_rvalid} !== '0) begin
                n_err++;
                $display("FAIL reset_outputs: got %b/%b/%b required 0/000/000", s_valid, m_ready, m_rvalid);
            end
            next_cycle();
        end
        rst = 1'b0; idle_inputs();
        settle();
        n_vec++;
        if (outstanding !== 3'd0) begin
            n_err++; $display("FAIL reset_outstanding: got %0d required 0", outstanding);
        end
        n_vec++;
        if (err_orphan !== 1'b0) begin
            n_err++; $display("FAIL reset_orphan: got %b required 0", err_orphan);
        end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_rdy, exp_rv;
        do_reset();
        m_valid = 3'b011; s_ready = 1'b1;
        m_addr = {$urandom, $urandom, $urandom};
        for (int i = 0; i < 6; i++) begin
            s_rvalid = (i > 0);
`ifdef MEMBUS_ARB_FIXED_PRIO_EN
            exp_rdy = 3'b001;
            exp_rv  = (i > 0) ? 3'b001 : 3'b000;
`else
            exp_rdy = (i % 2 == 0) ? 3'b001 : 3'b010;
            exp_rv  = (i == 0) ? 3'b000 : (((i - 1) % 2 == 0) ? 3'b001 : 3'b010);
`endif
            settle();
            n_vec++;
            if (m_ready !== exp_rdy) begin
                n_err++; $display("FAIL rr_grant[%0d]: got %b required %b", i, m_ready, exp_rdy);
            end
            n_vec++;
            if (m_rvalid !== exp_rv) begin
                n_err++; $display("FAIL rr_resp[%0d]: got %b required %b", i, m_rvalid, exp_rv);
            end
            if (i > 0) begin
                n_vec++;
                if (outstanding !== 3'd1) begin
                    n_err++; $display("FAIL rr_outstanding[%0d]: got %0d required 1", i, outstanding);
                end
            end
            next_cycle();
        end
        m_valid = '0; s_rvalid = 1'b1;
`ifdef MEMBUS_ARB_FIXED_PRIO_EN
        exp_rv = 3'b001;
`else
        exp_rv = 3'b010;
`endif
        settle();
        n_vec++;
        if (m_rvalid !== exp_rv) begin
            n_err++; $display("FAIL rr_last_resp: got %b required %b", m_rvalid, exp_rv);
        end
        next_cycle();
        s_rvalid = 1'b0;
        settle();
        n_vec++;
        if (outstanding !== 3'd0) begin
            n_err++; $display("FAIL rr_drained: got %0d required 0", outstanding);
        end
        next_cycle();
    endtask

    task automatic test_addr_map();
        do_reset();
        m_valid = 3'b001; s_ready = 1'b0;
        m_addr[0 +: IAW] = 32'h0000_1008;
        settle();
        n_vec++;
        if ({s_valid, m_ready, s_addr} !== {1'b1, 3'b000, 10'h201}) begin
            n_err++; $display("FAIL addr_map_a: got v=%b r=%b a=%h required v=1 r=000 a=201", s_valid, m_ready, s_addr);
        end
        next_cycle();
        m_addr[0 +: IAW] = 32'hFFFF_FFF8;
        settle();
        n_vec++;
        if (s_addr !== 10'h3FF) begin
            n_err++; $display("FAIL addr_map_b: got %h required 3ff", s_addr);
        end
        next_cycle();
    endtask

    task automatic test_full();
        do_reset();
        m_valid = 3'b001; s_ready = 1'b1; s_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            n_vec++;
            if ({outstanding, m_ready} !== {3'(i), 3'b001}) begin
                n_err++; $display("FAIL full_fill[%0d]: got out=%0d r=%b required out=%0d r=001", i, outstanding, m_ready, i);
            end
            next_cycle();
        end
        settle();
        n_vec++;
        if ({outstanding, s_valid, m_ready} !== {3'd4, 1'b0, 3'b000}) begin
            n_err++; $display("FAIL full_block: got out=%0d v=%b r=%b required out=4 v=0 r=000", outstanding, s_valid, m_ready);
        end
        next_cycle();
        s_rvalid = 1'b1;
        settle();
        n_vec++;
        if ({s_valid, m_ready, m_rvalid} !== {1'b1, 3'b001, 3'b001}) begin
            n_err++; $display("FAIL full_pushpop: got v=%b r=%b rv=%b required v=1 r=001 rv=001", s_valid, m_ready, m_rvalid);
        end
        next_cycle();
        m_valid = '0;
        for (int i = 0; i < 4; i++) begin
            settle();
            n_vec++;
            if ({outstanding, m_rvalid} !== {3'(4 - i), 3'b001}) begin
                n_err++; $display("FAIL full_drain[%0d]: got out=%0d rv=%b required out=%0d rv=001", i, outstanding, m_rvalid, 4 - i);
            end
            next_cycle();
        end
        s_rvalid = 1'b0;
        settle();
        n_vec++;
        if ({outstanding, err_orphan} !== {3'd0, 1'b0}) begin
            n_err++; $display("FAIL full_empty: got out=%0d orph=%b required out=0 orph=0", outstanding, err_orphan);
        end
        next_cycle();
    endtask

    task automatic test_lock();
        logic [AW-1:0] exp_a;
        do_reset();
        m_addr = {32'h0000_0200, 32'h0000_0100, 32'h0000_0040};
        m_valid = 3'b001; s_ready = 1'b1;
        settle();
        n_vec++;
        if (m_ready !== 3'b001) begin
            n_err++; $display("FAIL lock_setup: got %b required 001", m_ready);
        end
        next_cycle();
        m_valid = 3'b010; s_ready = 1'b0; s_rvalid = 1'b1;
        settle();
        n_vec++;
        if ({s_valid, m_ready, s_addr} !== {1'b1, 3'b000, 10'h020}) begin
            n_err++; $display("FAIL lock_stall: got v=%b r=%b a=%h required v=1 r=000 a=020", s_valid, m_ready, s_addr);
        end
        next_cycle();
        m_valid = 3'b011; s_rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            n_vec++;
            if ({m_ready, s_addr} !== {3'b000, 10'h020}) begin
                n_err++; $display("FAIL lock_hold[%0d]: got r=%b a=%h required r=000 a=020", i, m_ready, s_addr);
            end
            next_cycle();
        end
        s_ready = 1'b1;
        settle();
        n_vec++;
        if (m_ready !== 3'b010) begin
            n_err++; $display("FAIL lock_accept: got %b required 010", m_ready);
        end
        next_cycle();
        settle();
        n_vec++;
        if (m_ready !== 3'b001) begin
            n_err++; $display("FAIL lock_after: got %b required 001", m_ready);
        end
        next_cycle();
        s_ready = 1'b0;
`ifdef MEMBUS_ARB_FIXED_PRIO_EN
        exp_a = 10'h008;
`else
        exp_a = 10'h020;
`endif
        settle();
        n_vec++;
        if (s_addr !== exp_a) begin
            n_err++; $display("FAIL lock_regrant: got %h required %h", s_addr, exp_a);
        end
        next_cycle();
        m_valid = 3'b001;
        settle();
        n_vec++;
        if ({s_valid, s_addr} !== {1'b1, 10'h008}) begin
            n_err++; $display("FAIL lock_release: got v=%b a=%h required v=1 a=008", s_valid, s_addr);
        end
        next_cycle();
    endtask

    task automatic test_orphan();
        do_reset();
        s_rvalid = 1'b1;
        settle();
        n_vec++;
        if ({m_rvalid, err_orphan} !== {3'b000, 1'b0}) begin
            n_err++; $display("FAIL orphan_resp: got rv=%b orph=%b required rv=000 orph=0", m_rvalid, err_orphan);
        end
        next_cycle();
        s_rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            n_vec++;
            if (err_orphan !== 1'b1) begin
                n_err++; $display("FAIL orphan_sticky[%0d]: got %b required 1", i, err_orphan);
            end
            next_cycle();
        end
        do_reset();
        settle();
        n_vec++;
        if (err_orphan !== 1'b0) begin
            n_err++; $display("FAIL orphan_clear: got %b required 0", err_orphan);
        end
        // a request in flight when reset hits must be forgotten
        m_valid = 3'b001; s_ready = 1'b1;
        next_cycle();
        do_reset();
        s_rvalid = 1'b1;
        settle();
        n_vec++;
        if ({outstanding, m_rvalid} !== {3'd0, 3'b000}) begin
            n_err++; $display("FAIL orphan_discard: got out=%0d rv=%b required out=0 rv=000", outstanding, m_rvalid);
        end
        next_cycle();
        s_rvalid = 1'b0;
        settle();
        n_vec++;
        if (err_orphan !== 1'b1) begin
            n_err++; $display("FAIL orphan_after_rst: got %b required 1", err_orphan);
        end
        next_cycle();
    endtask

    task automatic test_random();
        logic [3+N+N+3:0] got_c, exp_c;
        logic [AW+1+DW+SW+DW-1:0] got_d, exp_d;
        bit slow;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            slow     = ((i / 200) % 2) == 1;
            rst      = ($urandom_range(0, 299) == 0);
            m_valid  = N'($urandom_range(0, 7));
            m_wen    = N'($urandom_range(0, 7));
            m_addr   = {$urandom, $urandom, $urandom};
            m_wdata  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            m_wmask  = (N*SW)'($urandom);
            s_rdata  = {$urandom, $urandom};
            s_ready  = ($urandom_range(0, 3) != 0);
            if (md_q.size() != 0) s_rvalid = slow ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
            else                  s_rvalid = ($urandom_range(0, 63) == 0);
            settle();
            got_c = {s_valid, m_ready, m_rvalid, outstanding, err_orphan};
            exp_c = {e_sval, e_mready, e_mrvalid, e_out, md_orphan};
            n_vec++;
            if (got_c !== exp_c) begin
                n_err++; $display("FAIL rand_ctrl[%0d]: got %b required %b", i, got_c, exp_c);
            end
            if (e_any && !rst) begin
                got_d = {s_addr, s_wen, s_wdata, s_wmask, m_rdata};
                exp_d = {e_addr, m_wen[e_g], m_wdata[e_g*DW +: DW], m_wmask[e_g*SW +: SW], s_rdata};
                n_vec++;
                if (got_d !== exp_d) begin
                    n_err++; $display("FAIL rand_data[%0d]: got %h required %h", i, got_d, exp_d);
                end
            end
            next_cycle();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        md_rr = 0; md_lock = -1; md_orphan = 1'b0;
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_addr_map();
        test_full();
        test_lock();
        test_orphan();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
